// File: rtl/pac_beat_mux.sv
// pac_beat_mux: sits behind the weighted round-robin arbiter. Steers the
// granted requester's beat into a 2-entry {id,data} output buffer, returns
// the beat handshake to the arbiter, and keeps per-requester saturating beat
// counters plus a sticky grant-protocol error flag.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   grant_i, grant_idx_i  one-hot grant and its index from the arbiter
//   src_valid_i/data_i    per-requester beat valid / flattened data
//   src_ready_o           per-requester beat accepted strobe
//   arb_src_valid_o       granted-index valid, back to the arbiter
//   arb_sink_ready_o      buffer has room, back to the arbiter
//   m_valid/data/id_o     registered output stream, m_ready_i from sink
//   cnt_sel_i, cnt_o      debug read of one beat counter
//   clr_i, err_o          clear counters/error, sticky protocol error

// Per-requester saturating beat counter.
module pac_beat_cnt #(
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o
);
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)               cnt_o <= '0;
    else if (inc_i && (cnt_o != '1))  cnt_o <= cnt_o + 1'b1;
  end
endmodule

module pac_beat_mux #(
  parameter int N         = 4,
  parameter int IDX_WIDTH = 2,
  parameter int DW        = 8,
  parameter int CW        = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         grant_i,
  input  logic [IDX_WIDTH-1:0] grant_idx_i,
  input  logic [N-1:0]         src_valid_i,
  input  logic [N*DW-1:0]      src_data_i,
  output logic [N-1:0]         src_ready_o,
  output logic                 arb_src_valid_o,
  output logic                 arb_sink_ready_o,
  output logic                 m_valid_o,
  output logic [DW-1:0]        m_data_o,
  output logic [IDX_WIDTH-1:0] m_id_o,
  input  logic                 m_ready_i,
  input  logic [IDX_WIDTH-1:0] cnt_sel_i,
  output logic [CW-1:0]        cnt_o,
  input  logic                 clr_i,
  output logic                 err_o
);

  typedef struct packed {
    logic [IDX_WIDTH-1:0] id;
    logic [DW-1:0]        data;
  } beat_t;

  logic [N-1:0][DW-1:0] src_data;
  logic [N-1:0][CW-1:0] cnt_q;
  logic [1:0]           occ_q;
  beat_t                head_q, tail_q, in_beat;
  logic                 push, pop, proto_err;

  assign src_data = src_data_i;

  // Indexed by grant_idx_i only: the arbiter's grant is a function of this,
  // so touching grant_i here would close a combinational loop.
  assign arb_src_valid_o  = src_valid_i[grant_idx_i];
  // Room is judged on registered occupancy, so no path from m_ready_i.
  assign arb_sink_ready_o = (occ_q != 2'd2);

  // Reset gating keeps src_ready_o low while held in reset.
  assign push = !rst_i && grant_i[grant_idx_i] && src_valid_i[grant_idx_i]
                && arb_sink_ready_o;
  assign pop  = (occ_q != 2'd0) && m_ready_i;

  always_comb begin
    src_ready_o = '0;
    if (push) src_ready_o[grant_idx_i] = 1'b1;
    in_beat.id   = grant_idx_i;
    in_beat.data = src_data[grant_idx_i];
  end

  // Head/tail buffer: head is always the oldest beat and directly drives m_*.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (push) begin
            head_q <= in_beat;
            occ_q  <= 2'd1;
          end
        end
        2'd1: begin
          case ({push, pop})
            2'b11: head_q <= in_beat;            // pass-through, stays at 1
            2'b10: begin tail_q <= in_beat; occ_q <= 2'd2; end
            2'b01: occ_q <= 2'd0;
            default: ;
          endcase
        end
        default: begin                           // full: push is blocked
          if (pop) begin
            head_q <= tail_q;
            occ_q  <= 2'd1;
          end
        end
      endcase
    end
  end

  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = head_q.data;
  assign m_id_o    = head_q.id;

  // Multiple grants, or a grant that disagrees with the index.
  assign proto_err = ($countones(grant_i) > 1) ||
                     ((grant_i != '0) && !grant_i[grant_idx_i]);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) err_o <= 1'b0;
    else if (proto_err) err_o <= 1'b1;
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt
    pac_beat_cnt #(.CW(CW)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clr_i),
      .inc_i (src_ready_o[g]),
      .cnt_o (cnt_q[g])
    );
  end

  assign cnt_o = cnt_q[cnt_sel_i];

endmodule

// File: tb/tb_pac_beat_mux.sv
module tb_pac_beat_mux;
  localparam int N = 4, IW = 2, DW = 8, CW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      grant;
  logic [IW-1:0]     idx;
  logic [N-1:0]      valid;
  logic [N-1:0][DW-1:0] data_a;
  logic [N*DW-1:0]   data;
  logic [N-1:0]      src_ready;
  logic              arb_src_valid, arb_sink_ready;
  logic              m_valid;
  logic [DW-1:0]     m_data;
  logic [IW-1:0]     m_id;
  logic              m_ready;
  logic [IW-1:0]     cnt_sel;
  logic [CW-1:0]     cnt;
  logic              clr, err;

  int checks = 0;
  int failures = 0;

  assign data = data_a;

  always #5 clk = ~clk;

  pac_beat_mux #(.N(N), .IDX_WIDTH(IW), .DW(DW), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst), .grant_i(grant), .grant_idx_i(idx),
    .src_valid_i(valid), .src_data_i(data), .src_ready_o(src_ready),
    .arb_src_valid_o(arb_src_valid), .arb_sink_ready_o(arb_sink_ready),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_id_o(m_id), .m_ready_i(m_ready),
    .cnt_sel_i(cnt_sel), .cnt_o(cnt), .clr_i(clr), .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one beat from requester i with a matching one-hot grant.
  task automatic offer(input int i, input logic [DW-1:0] d);
    idx       = IW'(i);
    grant     = N'(1) << i;
    valid     = N'(1) << i;
    data_a[i] = d;
  endtask

  task automatic idle();
    grant = '0; valid = '0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; m_ready = 1'b0; cnt_sel = '0;
    grant = '0; idx = '0; valid = '0; data_a = '0;
    tick(); tick();

    // Held in reset with a live offer: nothing accepted, outputs cleared.
    offer(1, 8'hA5); #1;
    chk("rst_src_ready", src_ready, 4'b0000);
    tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_id", m_id, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", cnt, 0);

    // Single beat, one-cycle latency.
    rst = 1'b0; m_ready = 1'b1; #1;
    chk("t1_src_ready", src_ready, 4'b0010);
    chk("t1_arb_src_valid", arb_src_valid, 1);
    chk("t1_arb_sink_ready", arb_sink_ready, 1);
    tick();
    chk("t1_m_valid", m_valid, 1);
    chk("t1_m_data", m_data, 8'hA5);
    chk("t1_m_id", m_id, 1);
    idle(); cnt_sel = 2'd1; #1;
    chk("t1_cnt1", cnt, 1);
    tick();
    chk("t1_drained", m_valid, 0);

    // Backpressure: fill to 2, third beat blocked.
    m_ready = 1'b0;
    offer(2, 8'h11); #1;
    chk("t2_push11", src_ready, 4'b0100);
    tick();
    offer(2, 8'h22); #1;
    chk("t2_push22", src_ready, 4'b0100);
    tick();
    offer(2, 8'h33); #1;
    chk("t2_full_sink_ready", arb_sink_ready, 0);
    chk("t2_full_src_ready", src_ready, 4'b0000);
    tick();
    chk("t2_hold_data", m_data, 8'h11);
    chk("t2_hold_id", m_id, 2);
    m_ready = 1'b1; #1;
    chk("t2_pop_full_src_ready", src_ready, 4'b0000);
    tick();
    chk("t2_out22", m_data, 8'h22);
    #1;
    chk("t2_push33", src_ready, 4'b0100);
    tick();
    chk("t2_out33", m_data, 8'h33);
    chk("t2_out33_valid", m_valid, 1);
    idle();
    tick();
    chk("t2_empty", m_valid, 0);
    cnt_sel = 2'd2; #1;
    chk("t2_cnt2", cnt, 3);

    // Streaming 10 beats alternating requesters 0 and 3, no bubbles.
    for (int i = 0; i < 10; i++) begin
      offer((i % 2 == 0) ? 0 : 3, 8'(8'h40 + i)); #1;
      chk("t3_src_ready", src_ready, (i % 2 == 0) ? 4'b0001 : 4'b1000);
      tick();
      chk("t3_valid", m_valid, 1);
      chk("t3_data", m_data, 8'h40 + i);
      chk("t3_id", m_id, (i % 2 == 0) ? 0 : 3);
    end
    idle();
    tick();
    chk("t3_empty", m_valid, 0);
    cnt_sel = 2'd0; #1;
    chk("t3_cnt0", cnt, 5);
    cnt_sel = 2'd3; #1;
    chk("t3_cnt3", cnt, 5);

    // Saturation and clear-beats-push.
    clr = 1'b1; tick(); clr = 1'b0;
    cnt_sel = 2'd0; #1;
    chk("t4_cleared", cnt, 0);
    for (int i = 0; i < 255; i++) begin
      offer(0, 8'(i)); tick();
    end
    #1;
    chk("t4_cnt_255", cnt, 8'hFF);
    tick();
    chk("t4_cnt_sat", cnt, 8'hFF);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t4_clr_wins", cnt, 0);
    chk("t4_clr_beat_kept", m_valid, 1);
    idle(); tick();
    chk("t4_err_clean", err, 0);

    // Protocol errors: a push still follows the push equation.
    grant = 4'b0101; idx = 2'd0; valid = 4'b0001; data_a[0] = 8'h77; #1;
    chk("t5_multi_push", src_ready, 4'b0001);
    tick();
    chk("t5_err_set", err, 1);
    chk("t5_beat_out", m_data, 8'h77);
    idle(); tick();
    chk("t5_err_sticky", err, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t5_err_clr", err, 0);
    grant = 4'b0001; idx = 2'd2; valid = 4'b0100; #1;
    chk("t5_mismatch_arb_valid", arb_src_valid, 1);
    chk("t5_mismatch_no_push", src_ready, 4'b0000);
    tick();
    chk("t5_mismatch_err", err, 1);
    idle();

    // Reset mid-transfer discards buffered beats.
    m_ready = 1'b0;
    offer(1, 8'h55); tick();
    offer(1, 8'h66); tick();
    idle(); #1;
    chk("t6_full", arb_sink_ready, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_m_valid", m_valid, 0);
    chk("t6_m_data", m_data, 0);
    chk("t6_m_id", m_id, 0);
    chk("t6_err", err, 0);
    for (int s = 0; s < N; s++) begin
      cnt_sel = IW'(s); #1;
      chk("t6_cnt", cnt, 0);
    end
    m_ready = 1'b1;
    offer(3, 8'h99); tick();
    chk("t6_after_valid", m_valid, 1);
    chk("t6_after_data", m_data, 8'h99);
    chk("t6_after_id", m_id, 3);
    idle(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
